// File: rtl/ctrl_pkt_gen_pkg.sv
// Menshen control-packet generator: shared types, offsets, helpers.
// Byte offsets are wire byte indices within beat 0.
package menshen_ctrl_pkg;

    localparam int AXIS_DW    = 512;
    localparam int AXIS_UW    = 128;
    localparam int BEAT_BYTES = 64;

    localparam int ETH_DST_OFF   = 0;
    localparam int ETH_SRC_OFF   = 6;
    localparam int VLAN_TPID_OFF = 12;
    localparam int VLAN_TCI_OFF  = 14;
    localparam int ETH_TYPE_OFF  = 16;

    localparam int IP_OFF        = 18;
    localparam int IP_VER_OFF    = IP_OFF + 0;
    localparam int IP_LEN_OFF    = IP_OFF + 2;
    localparam int IP_TTL_OFF    = IP_OFF + 8;
    localparam int IP_PROTO_OFF  = IP_OFF + 9;
    localparam int IP_CSUM_OFF   = IP_OFF + 10;
    localparam int IP_SRC_OFF    = IP_OFF + 12;
    localparam int IP_DST_OFF    = IP_OFF + 16;

    localparam int UDP_OFF       = 38;
    localparam int UDP_SPORT_OFF = UDP_OFF + 0;
    localparam int UDP_DPORT_OFF = UDP_OFF + 2;
    localparam int UDP_LEN_OFF   = UDP_OFF + 4;

    localparam int CTRL_RES_OFF  = 46;
    localparam int CTRL_MOD_OFF  = 47;
    localparam int CTRL_IDX_OFF  = 48;
    localparam int PAYLOAD_OFF   = 64;

    localparam logic [15:0] ETHTYPE_VLAN   = 16'h8100;
    localparam logic [15:0] ETHTYPE_IPV4   = 16'h0800;
    localparam logic [15:0] CTRL_UDP_SPORT = 16'h04D2;
    localparam logic [15:0] CTRL_UDP_DPORT = 16'hF1F2;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_TTL         = 8'h40;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    // IPv4(20) + UDP(8) + ctrl(18) bytes precede the payload in the IP datagram.
    localparam logic [15:0] IP_LEN_BASE  = 16'd46;
    localparam logic [15:0] UDP_LEN_BASE = 16'd26;

    typedef struct packed {
        logic [7:0]  module_id;
        logic [7:0]  resource_id;
        logic [31:0] index;
        logic [15:0] len;
    } ctrl_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CSUM,
        ST_HDR,
        ST_PAY
    } gen_state_e;

    // Place a network-order field so its MSB lands on the lowest byte.
    function automatic logic [15:0] be16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] be32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [63:0] tail_keep(input logic [5:0] r);
        if (r == 6'd0) return '1;
        return (64'd1 << r) - 64'd1;
    endfunction

endpackage

// File: rtl/ctrl_pkt_gen_if.sv
// AXI-Stream bundle for the control-packet generator output.
// master drives the beat, slave returns tready.
interface ctrl_pkt_gen_if
    import menshen_ctrl_pkg::*;
#(
    parameter int DW = AXIS_DW,
    parameter int UW = AXIS_UW
) ();

    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0]   tuser;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    modport master (
        output tdata, tkeep, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tvalid, tlast,
        output tready
    );

endinterface

// File: rtl/ctrl_pkt_ipv4_csum.sv
// IPv4 header checksum for config packets.
// Only total_len varies; all other header words are constants.
module ctrl_pkt_ipv4_csum
    import menshen_ctrl_pkg::*;
#(
    parameter logic [31:0] SRC_IP = 32'h6F6F6F6F,
    parameter logic [31:0] DST_IP = 32'hDEDEDEDE
) (
    input  logic [15:0] total_len,
    output logic [15:0] csum
);

    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // One's-complement sum of the non-zero header words, folded twice.
    always_comb begin
        sum = 20'({IP_VER_IHL, 8'h00})
            + 20'(total_len)
            + 20'({IP_TTL, IP_PROTO_UDP})
            + 20'(SRC_IP[31:16])
            + 20'(SRC_IP[15:0])
            + 20'(DST_IP[31:16])
            + 20'(DST_IP[15:0]);
        fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
        fold2 = fold1[15:0] + 16'(fold1[16]);
        csum  = ~fold2;
    end

endmodule

// File: rtl/ctrl_pkt_gen.sv
// Builds Menshen reconfiguration packets from single-cycle commands.
// Beat 0 carries all headers; payload follows from beat 1.
module ctrl_pkt_gen
    import menshen_ctrl_pkg::*;
#(
    parameter int          C_AXIS_DATA_WIDTH  = 512,
    parameter int          C_AXIS_TUSER_WIDTH = 128,
    parameter int          PAYLOAD_MAX_BYTES  = 128,
    parameter logic [15:0] VLAN_TCI           = 16'h000F,
    parameter logic [47:0] DST_MAC            = 48'h0B0A09080706,
    parameter logic [47:0] SRC_MAC            = 48'h050403020100,
    parameter logic [31:0] SRC_IP             = 32'h6F6F6F6F,
    parameter logic [31:0] DST_IP             = 32'hDEDEDEDE
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [7:0]                     cmd_module_id,
    input  logic [7:0]                     cmd_resource_id,
    input  logic [31:0]                    cmd_index,
    input  logic [15:0]                    cmd_len,
    input  logic [PAYLOAD_MAX_BYTES*8-1:0] cmd_payload,
    output logic                           cmd_len_err,
    ctrl_pkt_gen_if.master                 m_axis
);

    localparam int NB = PAYLOAD_MAX_BYTES / BEAT_BYTES;
    localparam int PW = (NB > 1) ? $clog2(NB) : 1;
    localparam int KW = C_AXIS_DATA_WIDTH / 8;

    gen_state_e state_q, state_d;
    ctrl_cmd_t  cmd_q;
    logic [PAYLOAD_MAX_BYTES*8-1:0] pay_q;
    logic [15:0] csum_q, csum_w;
    logic [15:0] ip_len, udp_len;
    logic [7:0]  cnt_q, nbeats_q;
    logic        len_err_q;
    logic        accept, len_bad, hs;
    logic        tvalid_w, tlast_w;
    logic [C_AXIS_DATA_WIDTH-1:0] hdr, tdata_w, pay_beat, byte_mask;
    logic [C_AXIS_DATA_WIDTH-1:0] pay_beats [NB];
    logic [KW-1:0] tkeep_w;
    logic [PW-1:0] pidx;

    assign accept  = cmd_valid & cmd_ready;
    assign len_bad = cmd_len > 16'(PAYLOAD_MAX_BYTES);
    assign hs      = tvalid_w & m_axis.tready;
    assign ip_len  = IP_LEN_BASE + cmd_q.len;
    assign udp_len = UDP_LEN_BASE + cmd_q.len;
    assign pidx    = PW'(cnt_q - 8'd1);

    ctrl_pkt_ipv4_csum #(
        .SRC_IP (SRC_IP),
        .DST_IP (DST_IP)
    ) u_csum (
        .total_len (ip_len),
        .csum      (csum_w)
    );

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        tvalid_w  = 1'b0;
        tlast_w   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && !len_bad) state_d = ST_CSUM;
            end
            ST_CSUM: state_d = ST_HDR;
            ST_HDR: begin
                tvalid_w = 1'b1;
                tlast_w  = (cmd_q.len == 16'd0);
                if (m_axis.tready)
                    state_d = tlast_w ? ST_IDLE : ST_PAY;
            end
            ST_PAY: begin
                tvalid_w = 1'b1;
                tlast_w  = (cnt_q == nbeats_q);
                if (m_axis.tready && tlast_w) state_d = ST_IDLE;
            end
        endcase
    end

    // Command latch, checksum register, beat counter, error pulse.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cmd_q     <= '0;
            pay_q     <= '0;
            csum_q    <= '0;
            cnt_q     <= '0;
            nbeats_q  <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (accept) begin
                if (len_bad) begin
                    len_err_q <= 1'b1;
                end else begin
                    cmd_q.module_id   <= cmd_module_id;
                    cmd_q.resource_id <= cmd_resource_id;
                    cmd_q.index       <= cmd_index;
                    cmd_q.len         <= cmd_len;
                    pay_q             <= cmd_payload;
                    nbeats_q <= 8'((cmd_len + 16'd63) >> 6);
                end
            end
            if (state_q == ST_CSUM) csum_q <= csum_w;
            if (hs) begin
                if (state_q == ST_HDR) cnt_q <= 8'd1;
                else                   cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // Beat 0 header image.
    always_comb begin
        hdr = '0;
        hdr[8*ETH_DST_OFF   +: 48] = DST_MAC;
        hdr[8*ETH_SRC_OFF   +: 48] = SRC_MAC;
        hdr[8*VLAN_TPID_OFF +: 16] = be16(ETHTYPE_VLAN);
        hdr[8*VLAN_TCI_OFF  +: 16] = be16(VLAN_TCI);
        hdr[8*ETH_TYPE_OFF  +: 16] = be16(ETHTYPE_IPV4);
        hdr[8*IP_VER_OFF    +: 8]  = IP_VER_IHL;
        hdr[8*IP_LEN_OFF    +: 16] = be16(ip_len);
        hdr[8*IP_TTL_OFF    +: 8]  = IP_TTL;
        hdr[8*IP_PROTO_OFF  +: 8]  = IP_PROTO_UDP;
        hdr[8*IP_CSUM_OFF   +: 16] = be16(csum_q);
        hdr[8*IP_SRC_OFF    +: 32] = be32(SRC_IP);
        hdr[8*IP_DST_OFF    +: 32] = be32(DST_IP);
        hdr[8*UDP_SPORT_OFF +: 16] = be16(CTRL_UDP_SPORT);
        hdr[8*UDP_DPORT_OFF +: 16] = be16(CTRL_UDP_DPORT);
        hdr[8*UDP_LEN_OFF   +: 16] = be16(udp_len);
        hdr[8*CTRL_RES_OFF  +: 8]  = cmd_q.resource_id;
        hdr[8*CTRL_MOD_OFF  +: 8]  = cmd_q.module_id;
        hdr[8*CTRL_IDX_OFF  +: 32] = cmd_q.index;
    end

    // Slice the latched payload into beats.
    always_comb begin
        for (int i = 0; i < NB; i++)
            pay_beats[i] = pay_q[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
    end

    // Beat data and keep; bytes past the payload end are forced to zero.
    always_comb begin
        tdata_w   = '0;
        tkeep_w   = '0;
        byte_mask = '0;
        pay_beat  = pay_beats[pidx];
        if (state_q == ST_HDR) begin
            tdata_w = hdr;
            tkeep_w = '1;
        end else if (state_q == ST_PAY) begin
            tkeep_w = tlast_w ? tail_keep(cmd_q.len[5:0]) : '1;
            for (int j = 0; j < KW; j++)
                byte_mask[8*j +: 8] = {8{tkeep_w[j]}};
            tdata_w = pay_beat & byte_mask;
        end
    end

    assign cmd_len_err   = len_err_q;
    assign m_axis.tdata  = tdata_w;
    assign m_axis.tkeep  = tkeep_w;
    assign m_axis.tuser  = {C_AXIS_TUSER_WIDTH{1'b0}};
    assign m_axis.tvalid = tvalid_w;
    assign m_axis.tlast  = tlast_w;

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// Directed bench for ctrl_pkt_gen: header fields, keep/last, stalls,
// length error and mid-packet reset.
module tb_ctrl_pkt_gen;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_module_id = '0;
    logic [7:0]    cmd_resource_id = '0;
    logic [31:0]   cmd_index = '0;
    logic [15:0]   cmd_len = '0;
    logic [1023:0] cmd_payload = '0;
    logic          cmd_len_err;

    ctrl_pkt_gen_if axis ();

    ctrl_pkt_gen dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_module_id   (cmd_module_id),
        .cmd_resource_id (cmd_resource_id),
        .cmd_index       (cmd_index),
        .cmd_len         (cmd_len),
        .cmd_payload     (cmd_payload),
        .cmd_len_err     (cmd_len_err),
        .m_axis          (axis)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    logic [511:0] cap_d [4];
    logic [63:0]  cap_k [4];
    logic         cap_l [4];
    logic [511:0] ref_d [4];
    int nb, gaps, unstable;
    bit done;

    logic [15:0]   cur_len;
    logic [1023:0] cur_pay;
    logic [7:0]    cur_res, cur_mod;
    logic [31:0]   cur_idx;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [1023:0] pat(input int seed);
        logic [1023:0] p;
        for (int k = 0; k < 128; k++) p[8*k +: 8] = 8'(k * 3 + seed);
        return p;
    endfunction

    function automatic logic [7:0] byte_of(input logic [511:0] d, input int k);
        return d[8*k +: 8];
    endfunction

    function automatic logic [15:0] ref_csum(input logic [15:0] tl);
        logic [31:0] s;
        s = 32'h4500 + 32'(tl) + 32'h4011 + 32'h6F6F + 32'h6F6F
          + 32'hDEDE + 32'hDEDE;
        s = (s & 32'hFFFF) + (s >> 16);
        s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    function automatic logic [511:0] exp_hdr();
        logic [7:0] b [64];
        logic [15:0] tl, ul, cs;
        logic [511:0] r;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]     = 8'(6 + i);
            b[6 + i] = 8'(i);
        end
        b[12] = 8'h81; b[15] = 8'h0F; b[16] = 8'h08; b[18] = 8'h45;
        tl = 16'd46 + cur_len;
        ul = 16'd26 + cur_len;
        cs = ref_csum(tl);
        b[20] = tl[15:8]; b[21] = tl[7:0];
        b[26] = 8'h40; b[27] = 8'h11;
        b[28] = cs[15:8]; b[29] = cs[7:0];
        for (int i = 30; i < 34; i++) b[i] = 8'h6F;
        for (int i = 34; i < 38; i++) b[i] = 8'hDE;
        b[38] = 8'h04; b[39] = 8'hD2; b[40] = 8'hF1; b[41] = 8'hF2;
        b[42] = ul[15:8]; b[43] = ul[7:0];
        b[46] = cur_res; b[47] = cur_mod;
        b[48] = cur_idx[7:0];   b[49] = cur_idx[15:8];
        b[50] = cur_idx[23:16]; b[51] = cur_idx[31:24];
        for (int i = 0; i < 64; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    task automatic verify(input string tag);
        int n;
        logic [511:0] d;
        logic [63:0]  k;
        n = (int'(cur_len) + 63) / 64;
        chk($sformatf("%s.beats", tag), 512'(nb), 512'(n + 1));
        chk($sformatf("%s.hdr", tag), cap_d[0], exp_hdr());
        chk($sformatf("%s.hkeep", tag), 512'(cap_k[0]), 512'({64{1'b1}}));
        chk($sformatf("%s.hlast", tag), 512'(cap_l[0]), 512'(cur_len == 0));
        for (int b = 1; b <= n && b < 4; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 64; j++) begin
                if ((b - 1) * 64 + j < int'(cur_len)) begin
                    d[8*j +: 8] = cur_pay[8*((b - 1) * 64 + j) +: 8];
                    k[j] = 1'b1;
                end
            end
            chk($sformatf("%s.b%0d.data", tag, b), cap_d[b], d);
            chk($sformatf("%s.b%0d.keep", tag, b), 512'(cap_k[b]), 512'(k));
            chk($sformatf("%s.b%0d.last", tag, b), 512'(cap_l[b]), 512'(b == n));
        end
        chk($sformatf("%s.nogap", tag), 512'(gaps), 512'(0));
        chk($sformatf("%s.stable", tag), 512'(unstable), 512'(0));
    endtask

    task automatic send_cmd(input logic [15:0] len, input logic [1023:0] pay,
                            input logic [7:0] res, input logic [7:0] md,
                            input logic [31:0] idx, input bit is_err);
        if (!is_err) begin
            cur_len = len; cur_pay = pay; cur_res = res;
            cur_mod = md; cur_idx = idx;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_len = len; cmd_payload = pay;
        cmd_resource_id = res; cmd_module_id = md; cmd_index = idx;
        @(negedge clk);
        chk("ready_idle", 512'(cmd_ready), 512'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("tvalid_T1", 512'(axis.tvalid), 512'(0));
        chk("len_err_T1", 512'(cmd_len_err), 512'(is_err));
        chk("ready_T1", 512'(cmd_ready), 512'(is_err));
    endtask

    task automatic capture(input bit rnd);
        bit started, stalled;
        logic [511:0] pd;
        logic [63:0]  pk;
        logic         pl;
        nb = 0; gaps = 0; unstable = 0; done = 0;
        started = 0; stalled = 0;
        pd = '0; pk = '0; pl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cap_d[i] = 'x; cap_k[i] = 'x; cap_l[i] = 1'bx;
        end
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk); #1;
            axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stalled && (!axis.tvalid || axis.tdata !== pd ||
                            axis.tkeep !== pk || axis.tlast !== pl))
                unstable++;
            if (started && !axis.tvalid) gaps++;
            stalled = 0;
            if (axis.tvalid) begin
                started = 1;
                if (axis.tready) begin
                    if (nb < 4) begin
                        cap_d[nb] = axis.tdata;
                        cap_k[nb] = axis.tkeep;
                        cap_l[nb] = axis.tlast;
                    end
                    nb++;
                    if (axis.tlast) done = 1;
                end else begin
                    stalled = 1;
                    pd = axis.tdata; pk = axis.tkeep; pl = axis.tlast;
                end
            end
        end
        chk("pkt_done", 512'(done), 512'(1));
        @(posedge clk); #1;
        axis.tready = 1'b1;
        @(negedge clk);
        chk("ready_after", 512'(cmd_ready), 512'(1));
        chk("idle_tvalid", 512'(axis.tvalid), 512'(0));
    endtask

    function automatic logic [15:0] resum(input logic [511:0] d);
        logic [31:0] s;
        s = 0;
        for (int i = 0; i < 10; i++)
            s += {16'h0, byte_of(d, 18 + 2*i), byte_of(d, 19 + 2*i)};
        s = (s & 32'hFFFF) + (s >> 16);
        s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    initial begin
        int pulses;
        axis.tready = 1'b1;
        #2;
        chk("rst_tvalid", 512'(axis.tvalid), 512'(0));
        chk("rst_tdata", axis.tdata, 512'(0));
        chk("rst_tkeep", 512'(axis.tkeep), 512'(0));
        chk("rst_tlast", 512'(axis.tlast), 512'(0));
        chk("rst_tuser", 512'(axis.tuser), 512'(0));
        chk("rst_ready", 512'(cmd_ready), 512'(1));
        chk("rst_lenerr", 512'(cmd_len_err), 512'(0));
        @(posedge clk); #1;
        aresetn = 1'b1;

        send_cmd(16'd2, 1024'h0404, 8'h13, 8'h00, 32'd1, 0);
        capture(0);
        verify("L2");
        chk("L2.b1keep", 512'(cap_k[1]), 512'(64'h3));
        chk("L2.b1data", cap_d[1], 512'h0404);
        chk("L2.iplen", 512'({byte_of(cap_d[0], 20), byte_of(cap_d[0], 21)}),
            512'(16'h0030));
        chk("L2.udplen", 512'({byte_of(cap_d[0], 42), byte_of(cap_d[0], 43)}),
            512'(16'h001C));
        chk("L2.csum", 512'({byte_of(cap_d[0], 28), byte_of(cap_d[0], 29)}),
            512'(16'hDE21));

        send_cmd(16'd20, pat(5), 8'hA1, 8'h2C, 32'h12345678, 0);
        capture(0);
        verify("L20");
        chk("L20.b1keep", 512'(cap_k[1]), 512'(64'h00000000000FFFFF));
        chk("L20.iplen", 512'({byte_of(cap_d[0], 20), byte_of(cap_d[0], 21)}),
            512'(16'h0042));
        chk("L20.udplen", 512'({byte_of(cap_d[0], 42), byte_of(cap_d[0], 43)}),
            512'(16'h002E));
        chk("L20.resum", 512'(resum(cap_d[0])), 512'(16'hFFFF));

        send_cmd(16'd128, pat(9), 8'h07, 8'h05, 32'hCAFE0002, 0);
        capture(0);
        verify("L128");

        send_cmd(16'd0, pat(1), 8'h02, 8'h03, 32'h4, 0);
        capture(0);
        verify("L0");

        send_cmd(16'd100, pat(77), 8'h44, 8'h55, 32'h00ABCDEF, 0);
        capture(0);
        verify("L100");
        for (int i = 0; i < 3; i++) ref_d[i] = cap_d[i];
        send_cmd(16'd100, pat(77), 8'h44, 8'h55, 32'h00ABCDEF, 0);
        capture(1);
        verify("L100r");
        for (int i = 0; i < 3; i++)
            chk($sformatf("L100r.same%0d", i), cap_d[i], ref_d[i]);

        send_cmd(16'd129, pat(3), 8'h01, 8'h01, 32'h0, 1);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cmd_len_err || axis.tvalid) pulses++;
        end
        chk("L129.quiet", 512'(pulses), 512'(0));
        send_cmd(16'd0, '0, 8'h09, 8'h0A, 32'h0B, 0);
        capture(0);
        verify("afterErr");

        send_cmd(16'd100, pat(11), 8'h21, 8'h22, 32'h23, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midpkt_tvalid", 512'(axis.tvalid), 512'(1));
        aresetn = 1'b0;
        #1;
        chk("arst_tvalid", 512'(axis.tvalid), 512'(0));
        chk("arst_tdata", axis.tdata, 512'(0));
        chk("arst_tkeep", 512'(axis.tkeep), 512'(0));
        chk("arst_tlast", 512'(axis.tlast), 512'(0));
        chk("arst_ready", 512'(cmd_ready), 512'(1));
        @(posedge clk); #1;
        aresetn = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (axis.tvalid) pulses++;
        end
        chk("arst_quiet", 512'(pulses), 512'(0));
        send_cmd(16'd65, pat(40), 8'h31, 8'h32, 32'h33, 0);
        capture(1);
        verify("postRst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
